// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Owns the program counter and fetches 32-bit instructions from
//            instruction memory over a req/ready handshake. Presents the
//            current instruction and its opcode to decode. On retirement it
//            computes the next PC (sequential or branch). It halts on a
//            misaligned branch target and keeps a wrapping retire counter.
// Ports    : clk, rst_n          - clock, async active-low reset
//            pc_src, imm_ext     - next-PC select and branch offset
//            exec_done           - current instruction retires
//            imem_req/addr       - fetch request and address (= pc)
//            imem_ready/rdata    - memory response
//            instr, op           - current instruction, opcode field
//            instr_valid         - instr holds a fetched, unretired word
//            pc, pc_plus4        - current PC, PC + 4
//            misaligned          - sticky misaligned-branch flag
//            retired_cnt         - retired instruction count
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_src,
   input  logic [31:0] imm_ext,
   input  logic        exec_done,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misaligned,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic        r_instr_valid;
   logic        w_instr_valid_nxt;
   logic        r_misaligned;
   logic        w_misaligned_nxt;
   logic [31:0] r_retired_cnt;
   logic [31:0] w_retired_cnt_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;

   // Both adders are plain 32-bit modulo; a negative offset wraps by
   // two's complement.
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_target   = pc_src ? (r_pc + imm_ext) : w_pc_plus4;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_valid <= 1'b0;
         r_misaligned  <= 1'b0;
         r_retired_cnt <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_misaligned  <= w_misaligned_nxt;
         r_retired_cnt <= w_retired_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_instr_nxt       = r_instr;
      w_instr_valid_nxt = r_instr_valid;
      w_misaligned_nxt  = r_misaligned;
      w_retired_cnt_nxt = r_retired_cnt;

      case (r_state)
         S_FETCH: begin
            if (imem_ready) begin
               w_instr_nxt       = imem_rdata;
               w_instr_valid_nxt = 1'b1;
               w_state_nxt       = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exec_done) begin
               w_instr_valid_nxt = 1'b0;
               w_retired_cnt_nxt = r_retired_cnt + 32'd1;
               if (w_target[1:0] == 2'b00) begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = S_FETCH;
               end else begin
                  // PC stays on the offending branch for post-mortem.
                  w_misaligned_nxt = 1'b1;
                  w_state_nxt      = S_HALT;
               end
            end
         end
         S_HALT: begin
            // Terminal until reset.
            w_instr_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_HALT;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs, all derived from registers
   // ------------------------------------------------------------------
   assign imem_req    = (r_state == S_FETCH);
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign op          = r_instr[6:0];
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign misaligned  = r_misaligned;
   assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. Expected fetches are
//            queued when memory answers and popped when instr_valid shows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        pc_src;
   logic [31:0] imm_ext;
   logic        exec_done;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  op;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misaligned;
   logic [31:0] retired_cnt;

   instr_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_src      (pc_src),
      .imm_ext     (imm_ext),
      .exec_done   (exec_done),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .op          (op),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .misaligned  (misaligned),
      .retired_cnt (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } fetch_t;

   fetch_t      exp_q[$];
   int          n_run;
   int          n_fail;
   logic [31:0] exp_retired;
   logic [31:0] last_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[27:4] ^ 24'hC3A5F0, 1'b1, a[8:2]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // FETCH at exp_pc with `waits` not-ready cycles, then a ready cycle.
   task automatic do_fetch(input int waits, input logic [31:0] exp_pc,
                           input logic [31:0] word);
      fetch_t f;
      for (int i = 0; i <= waits; i++) begin
         n_run++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h",
                     imem_req, imem_addr, exp_pc);
         end
         if (i < waits) begin
            imem_ready = 1'b0;
            tick();
         end
      end
      imem_ready = 1'b1;
      imem_rdata = word;
      exp_q.push_back('{addr: exp_pc, word: word});
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      f = exp_q.pop_front();
      last_word = f.word;
      n_run++;
      if (instr_valid !== 1'b1 || instr !== f.word || op !== f.word[6:0] ||
          pc !== f.addr || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_data: valid=%b instr=%h op=%h pc=%h req=%b, required 1 %h %h %h 0",
                  instr_valid, instr, op, pc, imem_req, f.word, f.word[6:0], f.addr);
      end
   endtask

   // Retire in EXEC, then check the next fetch address.
   task automatic do_retire(input logic src, input logic [31:0] imm,
                            input logic [31:0] exp_next);
      pc_src    = src;
      imm_ext   = imm;
      exec_done = 1'b1;
      exp_retired = exp_retired + 32'd1;
      tick();
      exec_done = 1'b0;
      n_run++;
      if (retired_cnt !== exp_retired || instr_valid !== 1'b0 ||
          imem_req !== 1'b1 || imem_addr !== exp_next) begin
         n_fail++;
         $display("FAIL retire: cnt=%h valid=%b req=%b addr=%h, required %h 0 1 %h",
                  retired_cnt, instr_valid, imem_req, imem_addr, exp_retired, exp_next);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_run++;
      if (pc !== C_RESET_PC || instr !== 32'd0 || op !== 7'd0 ||
          instr_valid !== 1'b0 || misaligned !== 1'b0 || retired_cnt !== 32'd0 ||
          imem_req !== 1'b1 || imem_addr !== C_RESET_PC || pc_plus4 !== 32'h104) begin
         n_fail++;
         $display("FAIL reset_values: pc=%h instr=%h op=%h v=%b mis=%b cnt=%h req=%b addr=%h p4=%h",
                  pc, instr, op, instr_valid, misaligned, retired_cnt, imem_req,
                  imem_addr, pc_plus4);
      end
      rst_n = 1'b1;
      exp_retired = 32'd0;
      exp_q.delete();
      tick();
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = C_RESET_PC + 32'(4 * i);
         do_fetch(0, a, mem_word(a));
         n_run++;
         if (pc_plus4 !== a + 32'd4) begin
            n_fail++;
            $display("FAIL pc_plus4: got %h required %h", pc_plus4, a + 32'd4);
         end
         do_retire(1'b0, 32'h1234_5679, a + 32'd4);
      end
      n_run++;
      if (retired_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL retired_three: got %h required 3", retired_cnt);
      end
   endtask

   task automatic test_branch();
      do_fetch(0, 32'h10C, mem_word(32'h10C));
      do_retire(1'b1, 32'hFFFF_FF14, 32'h20);
      do_fetch(0, 32'h20, mem_word(32'h20));
      do_retire(1'b1, 32'hFFFF_FFF0, 32'h10);
      do_fetch(0, 32'h10, mem_word(32'h10));
      do_retire(1'b1, 32'h0000_0010, 32'h20);
      do_fetch(0, 32'h20, mem_word(32'h20));
      do_retire(1'b0, 32'hFFFF_FFF0, 32'h24);
   endtask

   task automatic test_mem_wait();
      do_fetch(0, 32'h24, mem_word(32'h24));
      do_retire(1'b1, 32'hFFFF_FFDC, 32'h0);
      do_fetch(3, 32'h0, 32'h0000_2003);
      n_run++;
      if (op !== 7'b0000011) begin
         n_fail++;
         $display("FAIL op_field: got %b required 0000011", op);
      end
      do_retire(1'b0, 32'h0, 32'h4);
   endtask

   task automatic test_wrap_spurious();
      do_fetch(0, 32'h4, mem_word(32'h4));
      do_retire(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
      // exec_done while fetching must be ignored
      pc_src = 1'b1; imm_ext = 32'h8; exec_done = 1'b1; imem_ready = 1'b0;
      tick();
      exec_done = 1'b0;
      n_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0 ||
          retired_cnt !== exp_retired) begin
         n_fail++;
         $display("FAIL spurious_exec: req=%b addr=%h v=%b cnt=%h, required 1 fffffffc 0 %h",
                  imem_req, imem_addr, instr_valid, retired_cnt, exp_retired);
      end
      do_fetch(0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
      // imem_ready while executing must be ignored
      imem_ready = 1'b1; imem_rdata = 32'h5555_AAAA;
      tick();
      imem_ready = 1'b0;
      n_run++;
      if (instr !== last_word || instr_valid !== 1'b1 || imem_req !== 1'b0 ||
          pc !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL spurious_ready: instr=%h v=%b req=%b pc=%h, required %h 1 0 fffffffc",
                  instr, instr_valid, imem_req, pc, last_word);
      end
      do_retire(1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_misaligned();
      do_fetch(0, 32'h0, mem_word(32'h0));
      do_retire(1'b1, 32'h40, 32'h40);
      do_fetch(0, 32'h40, mem_word(32'h40));
      pc_src = 1'b1; imm_ext = 32'h6; exec_done = 1'b1;
      exp_retired = exp_retired + 32'd1;
      tick();
      n_run++;
      if (misaligned !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40 ||
          instr_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         n_fail++;
         $display("FAIL misaligned_halt: mis=%b req=%b pc=%h v=%b cnt=%h, required 1 0 40 0 %h",
                  misaligned, imem_req, pc, instr_valid, retired_cnt, exp_retired);
      end
      imem_ready = 1'b1; pc_src = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_run++;
         if (misaligned !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40 ||
             instr_valid !== 1'b0 || retired_cnt !== exp_retired) begin
            n_fail++;
            $display("FAIL halt_hold: mis=%b req=%b pc=%h v=%b cnt=%h, required 1 0 40 0 %h",
                     misaligned, imem_req, pc, instr_valid, retired_cnt, exp_retired);
         end
      end
      exec_done = 1'b0; imem_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      // Leave HALT through reset, then stall mid-fetch.
      #3 rst_n = 1'b0;
      #1;
      n_run++;
      if (misaligned !== 1'b0 || pc !== C_RESET_PC || imem_req !== 1'b1 ||
          retired_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_from_halt: mis=%b pc=%h req=%b cnt=%h",
                  misaligned, pc, imem_req, retired_cnt);
      end
      tick();
      rst_n = 1'b1;
      exp_retired = 32'd0;
      exp_q.delete();
      do_fetch(0, C_RESET_PC, mem_word(C_RESET_PC));
      do_retire(1'b0, 32'h0, 32'h104);
      imem_ready = 1'b0;
      tick();
      tick();
      #3 rst_n = 1'b0;
      #1;
      n_run++;
      if (pc !== C_RESET_PC || imem_addr !== C_RESET_PC || imem_req !== 1'b1 ||
          retired_cnt !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_fetch: pc=%h addr=%h req=%b cnt=%h instr=%h v=%b",
                  pc, imem_addr, imem_req, retired_cnt, instr, instr_valid);
      end
      // Ready while reset is held must not start a fetch.
      imem_ready = 1'b1; imem_rdata = 32'h1111_2222;
      tick();
      imem_ready = 1'b0;
      n_run++;
      if (instr_valid !== 1'b0 || instr !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hold: v=%b instr=%h, required 0 0", instr_valid, instr);
      end
      rst_n = 1'b1;
      tick();
      do_fetch(1, C_RESET_PC, 32'hABCD_0013);
      #3 rst_n = 1'b0;
      #1;
      n_run++;
      if (instr_valid !== 1'b0 || instr !== 32'd0 || op !== 7'd0 ||
          imem_req !== 1'b1 || imem_addr !== C_RESET_PC) begin
         n_fail++;
         $display("FAIL reset_in_exec: v=%b instr=%h op=%h req=%b addr=%h",
                  instr_valid, instr, op, imem_req, imem_addr);
      end
      tick();
      rst_n = 1'b1;
      exp_retired = 32'd0;
      exp_q.delete();
      do_fetch(2, C_RESET_PC, mem_word(C_RESET_PC));
      do_retire(1'b0, 32'h0, 32'h104);
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      exp_retired = 32'd0;
      last_word = 32'd0;
      rst_n = 1'b0;
      pc_src = 1'b0;
      imm_ext = 32'd0;
      exec_done = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      test_reset();
      test_sequential();
      test_branch();
      test_mem_wait();
      test_wrap_spurious();
      test_misaligned();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream neighbour of the main decoder: owns the program counter, fetches 32-bit instructions from instruction memory over a req/ready handshake, and presents the current instruction and its opcode field to the decode/execute logic. On instruction retirement it computes the next PC from the decoder's `PCSrc` and the extended branch immediate, and it halts on a misaligned branch target. It also keeps a wrapping retired-instruction counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: single clock, all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc_src`  in  1: decoder `PCSrc`, sampled only with `exec_done`.
- `imm_ext`  in  32: sign-extended branch offset, sampled only with `exec_done`.
- `exec_done`  in  1: current instruction retires this cycle.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address, equal to `pc`.
- `imem_ready`  in  1: memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32: instruction word.
- `instr`  out  32: registered current instruction.
- `op`  out  7: `instr[6:0]`, feeds decoder `op`.
- `instr_valid`  out  1: `instr`/`op` hold a fetched, unretired instruction.
- `pc`  out  32: PC of the current instruction.
- `pc_plus4`  out  32: `pc + 4`, combinational.
- `misaligned`  out  1: sticky; branch target had bits [1:0] != 0.
- `retired_cnt`  out  32: count of retired instructions.

## Operation
- States: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, go EXEC. Else stay, holding `imem_req` and address stable.
- EXEC: `imem_req`=0. On `exec_done`=1: target = `pc_src` ? `pc`+`imm_ext` : `pc`+4; `instr_valid`<=0; `retired_cnt`<=`retired_cnt`+1.
  - If target[1:0]==0: `pc`<=target, go FETCH.
  - Else: `pc` unchanged, `misaligned`<=1, go HALT.
- HALT: `imem_req`=0, `instr_valid`=0; stays until reset. `exec_done`, `imem_ready` ignored.
- `imem_ready` ignored outside FETCH; `exec_done` ignored outside EXEC.
- Arithmetic: 32-bit modulo; `pc`+4 at 32'hFFFF_FFFC wraps to 0; `pc`+`imm_ext` wraps likewise (negative offsets by two's complement). `retired_cnt` wraps from 32'hFFFF_FFFF to 0.
- Retirement causing a misaligned halt still increments `retired_cnt`.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0, `op`=0, `instr_valid`=0, `misaligned`=0, `retired_cnt`=0, state FETCH, so `imem_req`=1 and `imem_addr`=`RESET_PC` immediately after reset deasserts.
- `imem_req`, `imem_addr`, `pc_plus4`, `op` combinational from registers; memory may answer in the request cycle (zero wait).
- Fetch latency: `instr_valid` rises the cycle after the `imem_ready` cycle.
- Minimum throughput: 2 cycles per instruction (FETCH with ready, EXEC with `exec_done`); each memory wait cycle adds one.
- `exec_done` in the same cycle `instr_valid` first shows 1 is legal; new `pc` visible next cycle together with `imem_req`=1.
- Reset asserted in any state, including mid-fetch with `imem_req` high: all outputs take reset values asynchronously; no pending fetch survives.

## Test plan
- Reset with `RESET_PC`=32'h100, `imem_ready` tied 1, `exec_done` pulsed each EXEC, `pc_src`=0 -> `imem_addr` 0x100,0x104,0x108; `instr_valid` alternates; `retired_cnt`=3 after three retirements.
- Memory wait: `imem_ready` low 3 cycles at PC 0x0 -> `imem_req` and `imem_addr`=0 held 4 cycles; `instr` = `imem_rdata` of the ready cycle; `op`=`instr[6:0]` (e.g. 7'b0000011 for 32'h0000_2003).
- Taken branch: PC 0x20, `pc_src`=1, `imm_ext`=32'hFFFF_FFF0 -> next `imem_addr`=0x10; with `pc_src`=0 instead -> 0x24.
- Misaligned: PC 0x40, `pc_src`=1, `imm_ext`=0x6 -> `misaligned`=1, HALT, `imem_req` stays 0, `pc`=0x40, further `exec_done`/`imem_ready` ignored, `retired_cnt` incremented once.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, retire with `pc_src`=0 -> next `imem_addr`=0; spurious `exec_done` during FETCH and `imem_ready` during EXEC -> no state change.
- Async reset asserted mid-wait in FETCH and again in EXEC -> outputs return to reset values within the same cycle, fetch restarts at `RESET_PC`.
